// File: rtl/alu_system_seq.sv
// -----------------------------------------------------------------------------
// alu_system_seq
//
// Self-sequencing 4-register ALU machine. An internal fetch/execute FSM reads
// 16-bit instructions (low byte at PC, high byte at PC+1) over a req/ack memory
// port, executes them against a 4-entry register file, and updates the
// {Z,C,N,O} flags.
//
// Instruction format: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
//
// Ports
//   Clock       in   rising-edge clock
//   Reset       in   synchronous, active-high; returns to IDLE, clears state
//   Start       in   one-cycle pulse, honoured only in IDLE or HALTED
//   MemReq      out  memory request, held until acknowledged
//   MemWE       out  1 = write, 0 = read (valid while MemReq)
//   MemAddr     out  request address (stable while MemReq)
//   MemWData    out  write data (stable while MemReq)
//   MemRData    in   read data, sampled when MemReq & MemAck
//   MemAck      in   completes the transfer in any cycle with MemReq & MemAck
//   Busy        out  1 in every state except IDLE and HALTED
//   Halted      out  1 in HALTED
//   PCOut       out  current PC
//   IROut       out  instruction register
//   ALUOutFlag  out  {Z,C,N,O}
//   DbgSel      in   register select for DbgOut
//   DbgOut      out  combinational read of GPR[DbgSel]
// -----------------------------------------------------------------------------
module alu_system_seq #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   output logic              MemReq,
   output logic              MemWE,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   input  logic [DATA_W-1:0] MemRData,
   input  logic              MemAck,
   output logic              Busy,
   output logic              Halted,
   output logic [ADDR_W-1:0] PCOut,
   output logic [15:0]       IROut,
   output logic [3:0]        ALUOutFlag,
   input  logic [1:0]        DbgSel,
   output logic [DATA_W-1:0] DbgOut
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_L,
      S_FETCH_H,
      S_EXEC,
      S_MEM,
      S_HALTED
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_LD   = 4'h2;
   localparam logic [3:0] OP_ST   = 4'h3;
   localparam logic [3:0] OP_MOV  = 4'h4;
   localparam logic [3:0] OP_ADD  = 4'h5;
   localparam logic [3:0] OP_SUB  = 4'h6;
   localparam logic [3:0] OP_AND  = 4'h7;
   localparam logic [3:0] OP_OR   = 4'h8;
   localparam logic [3:0] OP_XOR  = 4'h9;
   localparam logic [3:0] OP_NOT  = 4'hA;
   localparam logic [3:0] OP_LSL  = 4'hB;
   localparam logic [3:0] OP_LSR  = 4'hC;
   localparam logic [3:0] OP_BRA  = 4'hD;
   localparam logic [3:0] OP_BZ   = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   // Flag bit positions inside {Z,C,N,O}
   localparam int FL_Z = 3;
   localparam int FL_C = 2;
   localparam int FL_O = 0;

   // Two's-complement overflow of a + b: operands agree in sign, result does not.
   function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                    input logic signed [DATA_W-1:0] b,
                                    input logic signed [DATA_W-1:0] r);
      return ((a < 0) == (b < 0)) && ((r < 0) != (a < 0));
   endfunction

   // Two's-complement overflow of a - b: operands differ in sign and the
   // result sign differs from the minuend.
   function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                    input logic signed [DATA_W-1:0] b,
                                    input logic signed [DATA_W-1:0] r);
      return ((a < 0) != (b < 0)) && ((r < 0) != (a < 0));
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [15:0]         ir_q, ir_d;
   logic [DATA_W-1:0]   gpr_q [4];
   logic [DATA_W-1:0]   gpr_d [4];
   logic [3:0]          flags_q, flags_d;
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   // Instruction decode
   logic [3:0]          op;
   logic [1:0]          rd, rs;
   logic [DATA_W-1:0]   imm_data;
   logic [ADDR_W-1:0]   imm_addr;
   logic [DATA_W-1:0]   opa, opb;
   logic                xfer;

   assign op       = ir_q[15:12];
   assign rd       = ir_q[11:10];
   assign rs       = ir_q[9:8];
   assign imm_data = DATA_W'(ir_q[7:0]);
   assign imm_addr = ADDR_W'(ir_q[7:0]);
   // Both operands come from the registered file, so rd==rs sees the old value.
   assign opa      = gpr_q[rd];
   assign opb      = gpr_q[rs];
   assign xfer     = req_q & MemAck;

   // ALU
   logic [DATA_W:0]     add_w, sub_w;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_c, alu_o;
   logic                alu_updates_flags;

   assign alu_updates_flags = (op >= OP_ADD) && (op <= OP_LSR);

   always_comb begin
      add_w   = {1'b0, opa} + {1'b0, opb};
      // The extra top bit of an unsigned subtraction is the borrow (opa < opb).
      sub_w   = {1'b0, opa} - {1'b0, opb};
      alu_res = opa;
      alu_c   = flags_q[FL_C];
      alu_o   = flags_q[FL_O];
      case (op)
         OP_ADD: begin
            alu_res = add_w[DATA_W-1:0];
            alu_c   = add_w[DATA_W];
            alu_o   = add_ovf(opa, opb, add_w[DATA_W-1:0]);
         end
         OP_SUB: begin
            alu_res = sub_w[DATA_W-1:0];
            alu_c   = sub_w[DATA_W];
            alu_o   = sub_ovf(opa, opb, sub_w[DATA_W-1:0]);
         end
         OP_AND: alu_res = opa & opb;
         OP_OR:  alu_res = opa | opb;
         OP_XOR: alu_res = opa ^ opb;
         OP_NOT: alu_res = ~opb;
         OP_LSL: begin
            alu_res = {opb[DATA_W-2:0], 1'b0};
            alu_c   = opb[DATA_W-1];
         end
         OP_LSR: begin
            alu_res = {1'b0, opb[DATA_W-1:1]};
            alu_c   = opb[0];
         end
         default: ;
      endcase
   end

   // Next-state and memory-port logic. The memory port is registered, so the
   // request for a state is set up on the edge that enters it; that is what
   // lets a zero-wait memory complete a transfer in the state's first cycle.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      gpr_d   = gpr_q;
      flags_d = flags_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      case (state_q)
         S_IDLE, S_HALTED: begin
            if (Start) begin
               state_d = S_FETCH_L;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = pc_q;
            end
         end

         S_FETCH_L: begin
            if (xfer) begin
               ir_d[7:0] = MemRData[7:0];
               state_d   = S_FETCH_H;
               addr_d    = pc_q + ADDR_W'(1);
            end
         end

         S_FETCH_H: begin
            if (xfer) begin
               ir_d[15:8] = MemRData[7:0];
               pc_d       = pc_q + ADDR_W'(2);
               state_d    = S_EXEC;
               req_d      = 1'b0;
            end
         end

         S_EXEC: begin
            state_d = S_FETCH_L;
            case (op)
               OP_NOP: ;
               OP_LDI: gpr_d[rd] = imm_data;
               OP_LD: begin
                  state_d = S_MEM;
                  req_d   = 1'b1;
                  we_d    = 1'b0;
                  addr_d  = imm_addr;
               end
               OP_ST: begin
                  state_d = S_MEM;
                  req_d   = 1'b1;
                  we_d    = 1'b1;
                  addr_d  = imm_addr;
                  wdata_d = opa;
               end
               OP_MOV: gpr_d[rd] = opb;
               OP_BRA: pc_d = imm_addr;
               // Flags here are those held on entry to EXEC.
               OP_BZ: if (flags_q[FL_Z]) pc_d = imm_addr;
               OP_HALT: state_d = S_HALTED;
               default: ;
            endcase

            if (alu_updates_flags) begin
               gpr_d[rd] = alu_res;
               flags_d   = {(alu_res == '0), alu_c, alu_res[DATA_W-1], alu_o};
            end

            // Fetch address follows any branch taken this cycle.
            if (state_d == S_FETCH_L) begin
               req_d  = 1'b1;
               we_d   = 1'b0;
               addr_d = pc_d;
            end
         end

         S_MEM: begin
            if (xfer) begin
               if (!we_q) gpr_d[rd] = MemRData;
               state_d = S_FETCH_L;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = pc_q;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         for (int i = 0; i < 4; i++) gpr_q[i] <= '0;
         flags_q <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         gpr_q   <= gpr_d;
         flags_q <= flags_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign MemReq     = req_q;
   assign MemWE      = we_q;
   assign MemAddr    = addr_q;
   assign MemWData   = wdata_q;
   assign Busy       = (state_q != S_IDLE) && (state_q != S_HALTED);
   assign Halted     = (state_q == S_HALTED);
   assign PCOut      = pc_q;
   assign IROut      = ir_q;
   assign ALUOutFlag = flags_q;
   assign DbgOut     = gpr_q[DbgSel];

endmodule

// File: tb/tb_alu_system_seq.sv
// Bench for alu_system_seq: table-driven programs with hand-derived results,
// hand-written wait-state / reset / Start sequences, and random programs
// checked against an instruction-level reference model.
module tb_alu_system_seq;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] dbg_sel = 2'd0;

   logic       mem_req, mem_we, mem_ack, busy, halted;
   logic [7:0] mem_addr, mem_wdata, mem_rdata, pc, dbg_out;
   logic [15:0] ir;
   logic [3:0] flags;

   // Main memory: loaded from img while load_mem is high, written by ST.
   logic [7:0] mem [256];
   logic [7:0] img [256];
   logic       load_mem = 1'b0;
   int         ack_delay = 0;
   int         wcnt = 0;

   assign mem_ack   = mem_req && (wcnt >= ack_delay);
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (rst) wcnt <= 0;
      else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (load_mem) mem <= img;
      else if (!rst && mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
   end

   alu_system_seq #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h00)) u_dut (
      .Clock(clk), .Reset(rst), .Start(start),
      .MemReq(mem_req), .MemWE(mem_we), .MemAddr(mem_addr), .MemWData(mem_wdata),
      .MemRData(mem_rdata), .MemAck(mem_ack),
      .Busy(busy), .Halted(halted), .PCOut(pc), .IROut(ir), .ALUOutFlag(flags),
      .DbgSel(dbg_sel), .DbgOut(dbg_out)
   );

   // Second instance starting at FE with a fixed ROM: LDI R3,C5 at FE; HALT at 00.
   logic       start2 = 1'b0;
   logic       req2, we2, ack2, busy2, halted2;
   logic [7:0] addr2, wdata2, rdata2, pc2, dbg2;
   logic [15:0] ir2;
   logic [3:0] flags2;

   assign ack2   = req2;
   assign rdata2 = (addr2 == 8'hFE) ? 8'hC5 : (addr2 == 8'hFF) ? 8'h1C :
                   (addr2 == 8'h01) ? 8'hF0 : 8'h00;

   alu_system_seq #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'hFE)) u_dut2 (
      .Clock(clk), .Reset(rst), .Start(start2),
      .MemReq(req2), .MemWE(we2), .MemAddr(addr2), .MemWData(wdata2),
      .MemRData(rdata2), .MemAck(ack2),
      .Busy(busy2), .Halted(halted2), .PCOut(pc2), .IROut(ir2), .ALUOutFlag(flags2),
      .DbgSel(dbg_sel), .DbgOut(dbg2)
   );

   // Port monitor: request fields must hold while a transfer waits, and the
   // PC may only move on the edge that completes a high-byte fetch.
   logic       mon_en = 1'b0;
   int         stab_err = 0, pc_err = 0, pc_chg = 0;
   logic       p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
   logic [7:0] p_addr = 8'h00, p_wdata = 8'h00, p_pc = 8'h00;

   always @(negedge clk) begin
      if (mon_en) begin
         if (p_req && !p_ack && mem_req &&
             (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_we !== p_we))
            stab_err <= stab_err + 1;
         if (pc !== p_pc) begin
            pc_chg <= pc_chg + 1;
            if (!(p_req && p_ack && !p_we && p_addr == 8'(p_pc + 8'd1)))
               pc_err <= pc_err + 1;
         end
      end
      p_req <= mem_req; p_ack <= mem_ack; p_we <= mem_we;
      p_addr <= mem_addr; p_wdata <= mem_wdata; p_pc <= pc;
   end

   int nvec = 0, nfail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] ins(input int op, input int rd, input int rs, input int imm);
      return {op[3:0], rd[1:0], rs[1:0], imm[7:0]};
   endfunction

   task automatic reset_load();
      @(negedge clk);
      rst = 1'b1; load_mem = 1'b1;
      @(negedge clk);
      rst = 1'b0; load_mem = 1'b0;
   endtask

   // Pulse Start, then count edges until Halted (bounded).
   task automatic run(input int budget, output int n);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      n = 0;
      while (!halted && n < budget) begin
         @(posedge clk); #1; n++;
      end
   endtask

   task automatic rd_reg(input int i, output logic [7:0] v);
      dbg_sel = i[1:0]; #1; v = dbg_out;
   endtask

   task automatic clear_img();
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
   endtask

   task automatic put(input int addr, input logic [15:0] w);
      img[addr] = w[7:0]; img[(addr + 1) % 256] = w[15:8];
   endtask

   // ---------------- table of programs ----------------
   typedef struct packed {
      logic [9:0][15:0] prog;
      logic [7:0] r0, r1, r2, r3;
      logic [3:0] fl;
      logic [7:0] pc;
      logic [7:0] cyc;
   } vec_t;

   logic [15:0] pq[$];
   vec_t        vecs[$];

   task automatic p(input logic [15:0] w);
      pq.push_back(w);
   endtask

   task automatic endv(input logic [7:0] r0, r1, r2, r3, input logic [3:0] fl,
                       input logic [7:0] pcv, input logic [7:0] cyc);
      vec_t v;
      v = '0;
      for (int i = 0; i < pq.size(); i++) v.prog[i] = pq[i];
      v.r0 = r0; v.r1 = r1; v.r2 = r2; v.r3 = r3; v.fl = fl; v.pc = pcv; v.cyc = cyc;
      vecs.push_back(v);
      pq.delete();
   endtask

   // ---------------- reference model ----------------
   int m_r[4];
   int m_fl, m_pc, m_cyc;
   int mm[256];

   function automatic int sx(input int v);
      return (v >= 128) ? v - 256 : v;
   endfunction

   // Executes the program in img one instruction at a time; d = wait states
   // per memory transfer (each transfer costs d+1 cycles, EXEC costs 1).
   task automatic model_run(input int d);
      int pcm, lo, hi, op, rd, rs, a, b, res, steps;
      bit z, c, n, o, done;
      for (int i = 0; i < 256; i++) mm[i] = int'(img[i]);
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      z = 0; c = 0; n = 0; o = 0; done = 0; steps = 0; pcm = 0; m_cyc = 0;
      while (!done && steps < 200) begin
         steps++;
         lo = mm[pcm]; hi = mm[(pcm + 1) % 256]; pcm = (pcm + 2) % 256;
         op = hi / 16; rd = (hi / 4) % 4; rs = hi % 4;
         a = m_r[rd]; b = m_r[rs]; res = 0;
         m_cyc += 2 * (d + 1) + 1;
         case (op)
            1: m_r[rd] = lo;
            2: begin m_r[rd] = mm[lo]; m_cyc += d + 1; end
            3: begin mm[lo] = a; m_cyc += d + 1; end
            4: m_r[rd] = b;
            5: begin res = a + b; c = (res > 255); o = (sx(a) + sx(b) > 127) || (sx(a) + sx(b) < -128); res = res % 256; end
            6: begin c = (a < b); o = (sx(a) - sx(b) > 127) || (sx(a) - sx(b) < -128); res = (a - b + 256) % 256; end
            7: res = a & b;
            8: res = a | b;
            9: res = a ^ b;
            10: res = 255 - b;
            11: begin c = (b >= 128); res = (b * 2) % 256; end
            12: begin c = (b % 2) == 1; res = b / 2; end
            13: pcm = lo;
            14: if (z) pcm = lo;
            15: done = 1;
            default: ;
         endcase
         if (op >= 5 && op <= 12) begin
            m_r[rd] = res; z = (res == 0); n = (res >= 128);
         end
      end
      m_fl = {28'd0, z, c, n, o};
      m_pc = pcm;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] v;
      logic [15:0] w;
      vec_t cur;

      // T1
      p(ins(1,0,0,8'h05)); p(ins(1,1,0,8'h03)); p(ins(5,0,1,0)); p(ins(15,0,0,0));
      endv(8'h08, 8'h03, 8'h00, 8'h00, 4'b0000, 8'h08, 8'd12);
      // T2 ADD wrap, then SUB borrow
      p(ins(1,0,0,8'hFF)); p(ins(1,1,0,8'h01)); p(ins(5,0,1,0)); p(ins(15,0,0,0));
      endv(8'h00, 8'h01, 8'h00, 8'h00, 4'b1100, 8'h08, 8'd12);
      p(ins(1,0,0,8'hFF)); p(ins(1,1,0,8'h01)); p(ins(5,0,1,0)); p(ins(6,0,1,0)); p(ins(15,0,0,0));
      endv(8'hFF, 8'h01, 8'h00, 8'h00, 4'b0110, 8'h0A, 8'd15);
      // T3 LSL out of MSB, then signed overflow
      p(ins(1,2,0,8'h80)); p(ins(11,3,2,0)); p(ins(15,0,0,0));
      endv(8'h00, 8'h00, 8'h80, 8'h00, 4'b1100, 8'h06, 8'd9);
      p(ins(1,2,0,8'h80)); p(ins(11,3,2,0)); p(ins(1,0,0,8'h7F)); p(ins(1,1,0,8'h01));
      p(ins(5,0,1,0)); p(ins(15,0,0,0));
      endv(8'h80, 8'h01, 8'h80, 8'h00, 4'b0011, 8'h0C, 8'd18);
      // T5 BZ taken / not taken, BRA (HALT sits at 0x20)
      p(ins(1,0,0,3)); p(ins(1,1,0,3)); p(ins(6,0,1,0)); p(ins(14,0,0,8'h20));
      p(ins(1,2,0,8'hAA)); p(ins(15,0,0,0));
      endv(8'h00, 8'h03, 8'h00, 8'h00, 4'b1000, 8'h22, 8'd15);
      p(ins(1,0,0,4)); p(ins(1,1,0,3)); p(ins(6,0,1,0)); p(ins(14,0,0,8'h20));
      p(ins(1,2,0,8'hAA)); p(ins(15,0,0,0));
      endv(8'h01, 8'h03, 8'hAA, 8'h00, 4'b0000, 8'h0C, 8'd18);
      p(ins(13,0,0,8'h20)); p(ins(1,3,0,8'h55)); p(ins(15,0,0,0));
      endv(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h22, 8'd6);
      // Logic ops, MOV, NOT with rd==rs; C/O untouched
      p(ins(1,0,0,8'hF0)); p(ins(1,1,0,8'h3C)); p(ins(4,2,0,0)); p(ins(7,2,1,0));
      p(ins(4,3,0,0)); p(ins(9,3,1,0)); p(ins(8,0,1,0)); p(ins(10,1,1,0)); p(ins(15,0,0,0));
      endv(8'hFC, 8'hC3, 8'h30, 8'hCC, 4'b0010, 8'h12, 8'd27);
      // LSR, SUB rd==rs
      p(ins(1,0,0,8'h81)); p(ins(12,1,0,0)); p(ins(6,0,0,0)); p(ins(15,0,0,0));
      endv(8'h00, 8'h40, 8'h00, 8'h00, 4'b1000, 8'h08, 8'd12);
      // ST then LD, zero-wait
      p(ins(1,1,0,8'h5A)); p(ins(3,1,0,8'h40)); p(ins(2,2,0,8'h40)); p(ins(15,0,0,0));
      endv(8'h00, 8'h5A, 8'h5A, 8'h00, 4'b0000, 8'h08, 8'd14);

      ack_delay = 0;
      for (int k = 0; k < vecs.size(); k++) begin
         cur = vecs[k];
         clear_img();
         for (int i = 0; i < 10; i++) put(2 * i, cur.prog[i]);
         put(8'h20, ins(15,0,0,0));
         reset_load();
         run(400, n);
         chk($sformatf("v%0d halted", k), 32'(halted), 32'd1);
         chk($sformatf("v%0d cycles", k), n, 32'(cur.cyc));
         chk($sformatf("v%0d pc", k), 32'(pc), 32'(cur.pc));
         chk($sformatf("v%0d flags", k), 32'(flags), 32'(cur.fl));
         rd_reg(0, v); chk($sformatf("v%0d r0", k), 32'(v), 32'(cur.r0));
         rd_reg(1, v); chk($sformatf("v%0d r1", k), 32'(v), 32'(cur.r1));
         rd_reg(2, v); chk($sformatf("v%0d r2", k), 32'(v), 32'(cur.r2));
         rd_reg(3, v); chk($sformatf("v%0d r3", k), 32'(v), 32'(cur.r3));
         if (k == 0) chk("v0 ir", 32'(ir), 32'hF000);
      end

      // Reset state after a run left non-zero state behind
      reset_load();
      #1;
      chk("rst busy", 32'(busy), 0);
      chk("rst halted", 32'(halted), 0);
      chk("rst pc", 32'(pc), 0);
      chk("rst ir", 32'(ir), 0);
      chk("rst flags", 32'(flags), 0);
      chk("rst memreq", 32'(mem_req), 0);
      chk("rst memwe", 32'(mem_we), 0);
      chk("rst memaddr", 32'(mem_addr), 0);
      chk("rst memwdata", 32'(mem_wdata), 0);
      for (int i = 0; i < 4; i++) begin
         rd_reg(i, v); chk($sformatf("rst r%0d", i), 32'(v), 0);
      end

      // T4: ST/LD with 3 wait states per transfer
      clear_img();
      put(0, ins(1,1,0,8'h5A)); put(2, ins(3,1,0,8'h40)); put(4, ins(2,2,0,8'h40)); put(6, ins(15,0,0,0));
      ack_delay = 3;
      reset_load();
      mon_en = 1'b1;
      run(400, n);
      mon_en = 1'b0;
      chk("T4 cycles", n, 44);
      chk("T4 stable", stab_err, 0);
      chk("T4 pc moves", pc_err, 0);
      chk("T4 pc changes", pc_chg, 4);
      chk("T4 pc", 32'(pc), 32'h08);
      chk("T4 mem40", 32'(mem[8'h40]), 32'h5A);
      rd_reg(2, v); chk("T4 r2", 32'(v), 32'h5A);

      // T6: reset while LD waits for ack
      clear_img();
      put(0, ins(1,0,0,8'h77)); put(2, ins(2,1,0,8'h40)); put(4, ins(15,0,0,0));
      img[8'h40] = 8'h33;
      ack_delay = 3;
      reset_load();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      n = 0;
      while (!(mem_req && !mem_we && mem_addr == 8'h40) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("T6 reached LD", 32'(mem_req && mem_addr == 8'h40), 1);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("T6 memreq", 32'(mem_req), 0);
      chk("T6 busy", 32'(busy), 0);
      chk("T6 halted", 32'(halted), 0);
      chk("T6 pc", 32'(pc), 0);
      rd_reg(0, v); chk("T6 r0", 32'(v), 0);
      rd_reg(1, v); chk("T6 r1", 32'(v), 0);
      @(negedge clk); rst = 1'b0;

      // Start pulses while Busy are ignored; Start from HALTED resumes
      clear_img();
      put(0, ins(1,0,0,8'h05)); put(2, ins(1,1,0,8'h03)); put(4, ins(5,0,1,0));
      put(6, ins(15,0,0,0)); put(8, ins(1,2,0,8'h09)); put(10, ins(15,0,0,0));
      ack_delay = 0;
      reset_load();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      n = 0;
      while (!halted && n < 100) begin
         start = (n == 4 || n == 7);
         @(posedge clk); #1; n++;
      end
      start = 1'b0;
      chk("busy-start cycles", n, 12);
      chk("busy-start pc", 32'(pc), 32'h08);
      rd_reg(0, v); chk("busy-start r0", 32'(v), 32'h08);
      run(100, n);
      chk("resume cycles", n, 6);
      chk("resume pc", 32'(pc), 32'h0C);
      rd_reg(2, v); chk("resume r2", 32'(v), 32'h09);

      // RESET_PC = FE: fetch FE,FF, then wrap to 00
      reset_load();
      #1;
      chk("wrap reset pc", 32'(pc2), 32'hFE);
      @(negedge clk); start2 = 1'b1;
      @(posedge clk); #1; start2 = 1'b0;
      n = 0;
      while (!halted2 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("wrap cycles", n, 6);
      chk("wrap pc", 32'(pc2), 32'h02);
      chk("wrap ir", 32'(ir2), 32'hF000);
      chk("wrap flags", 32'(flags2), 0);
      chk("wrap idle port", 32'({busy2, we2, wdata2}), 0);
      dbg_sel = 2'd3; #1;
      chk("wrap r3", 32'(dbg2), 32'hC5);

      // Random programs against the reference model
      for (int t = 0; t < 20; t++) begin
         int len, d, op, imm;
         int bad;
         len = $urandom_range(6, 12);
         d = $urandom_range(0, 2);
         clear_img();
         for (int a = 8'h80; a < 8'h90; a++) img[a] = 8'($urandom_range(0, 255));
         for (int i = 0; i < len; i++) begin
            op = $urandom_range(0, 12);
            imm = (op == 2 || op == 3) ? 8'h80 + $urandom_range(0, 15) : $urandom_range(0, 255);
            w = ins(op, $urandom_range(0, 3), $urandom_range(0, 3), imm);
            put(2 * i, w);
         end
         put(2 * len, ins(15,0,0,0));
         model_run(d);
         ack_delay = d;
         reset_load();
         run(2000, n);
         chk($sformatf("rnd%0d cycles", t), n, m_cyc);
         chk($sformatf("rnd%0d pc", t), 32'(pc), m_pc);
         chk($sformatf("rnd%0d flags", t), 32'(flags), m_fl);
         for (int i = 0; i < 4; i++) begin
            rd_reg(i, v); chk($sformatf("rnd%0d r%0d", t, i), 32'(v), m_r[i]);
         end
         bad = 0;
         for (int a = 8'h80; a < 8'h90; a++) if (int'(mem[a]) != mm[a]) bad++;
         chk($sformatf("rnd%0d data bytes differing", t), bad, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
